jump_charge_controller: RTL and testbench
=========================================

# jump_charge_controller

Input-side producer of the `charge_bar` value consumed by the charge-bar seven-segment display. It synchronizes and debounces the raw jump button, ramps a charge value while the button is held and the player is grounded, and on release hands the final charge to the physics block over a valid/ready handshake. It sits between the board button pins and both the physics engine and the charge-bar display.

## Interface
- `PHY_WIDTH`, 16: width of the charge and power values.
- `DEBOUNCE_CYCLES`, 100_000: number of consecutive stable synchronized samples required to change the debounced level.
- `CHARGE_TICK`, 5_000: sys_clk cycles per charge increment.
- `CHARGE_STEP`, 1: increment per tick.
- `MAX_CHARGE`, 1100: saturation value; must satisfy `MAX_CHARGE < 2**PHY_WIDTH`.
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `btn_jump`  in  1  raw asynchronous button, active-high.
- `on_ground`  in  1  physics status; charging is allowed only while this is 1.
- `jump_ready`  in  1  physics accepts the jump.
- `charge_bar`  out  PHY_WIDTH  live charge; 0 when not charging.
- `jump_valid`  out  1  jump request pending.
- `jump_power`  out  PHY_WIDTH  charge captured at release; valid while `jump_valid` is 1.

## Operation
- Input path: 2-flop synchronizer, then the debouncer. The debounced level flips only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- A registered copy of the debounced level gives a `press` (rising edge) pulse and a `release` (falling edge) pulse.
- FSM states are IDLE, CHARGING and FIRE.
- IDLE:
  - `charge_bar`=0, `jump_valid`=0.
  - On `press` with `on_ground`=1: go to CHARGING, `charge_bar`<=1, tick counter<=0.
  - On `press` with `on_ground`=0: ignored. A button that is already held never starts a charge; a fresh edge is required.
- CHARGING:
  - The tick counter counts 0..`CHARGE_TICK`-1.
  - At terminal count: `charge_bar` <= min(`charge_bar`+`CHARGE_STEP`, `MAX_CHARGE`), computed one bit wider than PHY_WIDTH so no wrap occurs.
  - At `MAX_CHARGE` the value holds and the state remains CHARGING.
  - `on_ground`=0 aborts: go to IDLE, `charge_bar`<=0, no jump is issued.
  - `release` with `on_ground`=1: go to FIRE, `jump_power`<=`charge_bar`, `jump_valid`<=1, `charge_bar`<=0.
- FIRE:
  - `jump_valid` and `jump_power` are held stable until `jump_ready`=1 is sampled. That cycle is the transfer; next state is IDLE and `jump_valid`<=0.
  - `press` in FIRE is ignored.
- Simultaneous events in CHARGING, in priority order: abort > release > tick. On a release cycle that is also a tick cycle, the increment is dropped and `jump_power` takes the pre-increment value.
- `jump_power` keeps its last value after transfer and is only meaningful while `jump_valid` is 1.

## Timing
- Reset values:
  - `charge_bar`=0, `jump_valid`=0, `jump_power`=0, state=IDLE.
  - Synchronizer, debounced level and its delayed copy all 0.
  - Both counters 0.
  - Reset mid-operation discards any pending jump; no transfer occurs.
- All outputs are registered.
- Press latency: a clean rising edge at the pin gives `charge_bar`=1 at 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge register) cycles, with ±1 cycle for pin-to-clock phase.
- Ramp: in steady charging, `charge_bar` increases every `CHARGE_TICK` cycles. The first increment comes `CHARGE_TICK` cycles after the value 1 appears.
- Release: `jump_valid` rises with the same latency as press, measured from the falling pin edge.
- Handshake: transfer occurs on the first edge where `jump_valid` and `jump_ready` are both 1. `jump_ready` held high in advance gives a 1-cycle `jump_valid` pulse.
- Back-to-back jumps: earliest next `press` acceptance is the cycle after returning to IDLE.

## Structure
- Package `jump_pkg`:
  - state enum `{IDLE, CHARGING, FIRE}`
  - default constants `DEF_MAX_CHARGE`=1100 (=55×20, matching the display threshold range), `DEF_CHARGE_TICK`, `DEF_DEBOUNCE_CYCLES`
- Sub-module `btn_debounce`: synchronizer, stability counter and debounced level output. It is reusable for other board buttons.
- Top level holds the edge detect, FSM, tick counter, saturating accumulator and handshake registers.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `CHARGE_TICK`=3, `MAX_CHARGE`=10, `on_ground`=1 unless stated.

- Bounce rejection: toggle `btn_jump` every 2 cycles for 20 cycles, then return it low -> `charge_bar` stays 0 and `jump_valid` never rises.
- Normal jump: hold the button for 20 cycles after debounce, then release with `jump_ready`=1 -> `charge_bar` climbs 1,2,3,… once every 3 cycles; `jump_valid` is a 1-cycle pulse with `jump_power` equal to the last `charge_bar`; `charge_bar`=0 afterward.
- Saturation: hold for 100 cycles -> `charge_bar` holds at 10; release gives `jump_power`=10.
- Backpressure: release with `jump_ready`=0 for 7 cycles, then 1 -> `jump_valid` and `jump_power` stable for 8 cycles; a press during this window does not start charging.
- Abort: drop `on_ground` mid-charge -> `charge_bar`=0 next cycle and no `jump_valid`. Button held from before `on_ground` returns -> no new charge until a re-press.
- Reset in FIRE: assert `sys_rst_n`=0 while `jump_valid`=1 -> all outputs 0 immediately; after deassertion, state is IDLE.

Source files
------------

// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - shared types and default constants for the jump charge path
// Purpose: FSM state encoding and default sizing constants used by the jump
//          charge controller, its handshake interface and the button debouncer.
// Ports:   none (package).
package jump_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHARGING = 2'd1,
    FIRE     = 2'd2
  } jump_state_e;

  localparam int DEF_PHY_WIDTH       = 16;
  // 55 x 20: matches the threshold range of the charge-bar display.
  localparam int DEF_MAX_CHARGE      = 1100;
  localparam int DEF_CHARGE_TICK     = 5_000;
  localparam int DEF_DEBOUNCE_CYCLES = 100_000;

endpackage

// File: rtl/jump_charge_controller_if.sv
// rtl/jump_charge_controller_if.sv - jump request valid/ready handshake bundle
// Purpose: carries the captured jump power from the charge controller to physics.
// Signals: jump_valid (master->slave) request pending
//          jump_power (master->slave) charge captured at release
//          jump_ready (slave->master) physics accepts the jump
interface jump_charge_controller_if
  import jump_pkg::*;
#(
  parameter int PHY_WIDTH = DEF_PHY_WIDTH
);

  logic                 jump_valid;
  logic                 jump_ready;
  logic [PHY_WIDTH-1:0] jump_power;

  modport master (output jump_valid, output jump_power, input jump_ready);
  modport slave  (input jump_valid, input jump_power, output jump_ready);

endinterface

// File: rtl/jump_charge_controller_debounce.sv
// rtl/jump_charge_controller_debounce.sv - button synchronizer and debouncer
// Purpose: 2-flop synchronizes a raw button, then changes the debounced level
//          only after DEBOUNCE_CYCLES consecutive samples disagree with it.
// Ports:   clk, rst_n (async active-low), btn_raw (async pin), level (debounced)
module btn_debounce
  import jump_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      if (sync_2 != level) begin
        // This cycle is the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
        if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level      <= sync_2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CW'(1);
        end
      end else begin
        // Any sample matching the current level is a bounce: restart.
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/jump_charge_controller.sv
// rtl/jump_charge_controller.sv - jump button charge ramp and jump request issue
// Purpose: debounces the jump button, ramps charge_bar while held on the ground,
//          and on release offers the final charge to physics via valid/ready.
// Ports:   sys_clk, sys_rst_n (async active-low), btn_jump (raw pin),
//          on_ground (charge enable), charge_bar (live charge),
//          jmp (master side of the jump_valid/jump_power/jump_ready handshake)
module jump_charge_controller
  import jump_pkg::*;
#(
  parameter int PHY_WIDTH       = DEF_PHY_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CHARGE_TICK     = DEF_CHARGE_TICK,
  parameter int CHARGE_STEP     = 1,
  parameter int MAX_CHARGE      = DEF_MAX_CHARGE
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     btn_jump,
  input  logic                     on_ground,
  output logic [PHY_WIDTH-1:0]     charge_bar,
  jump_charge_controller_if.master jmp
);

  localparam int TW = (CHARGE_TICK > 1) ? $clog2(CHARGE_TICK) : 1;
  localparam logic [PHY_WIDTH:0] MAX_W  = (PHY_WIDTH + 1)'(MAX_CHARGE);
  localparam logic [PHY_WIDTH:0] STEP_W = (PHY_WIDTH + 1)'(CHARGE_STEP);

  logic                 btn_level;
  logic                 btn_level_d;
  logic                 press;
  logic                 rel;
  logic                 tick_done;
  logic [PHY_WIDTH:0]   charge_sum;
  logic [PHY_WIDTH-1:0] charge_next;
  logic [TW-1:0]        tick_cnt;
  jump_state_e          state;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .btn_raw (btn_jump),
    .level   (btn_level)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_level_d <= 1'b0;
    end else begin
      btn_level_d <= btn_level;
    end
  end

  assign press     = btn_level & ~btn_level_d;
  assign rel       = ~btn_level & btn_level_d;
  assign tick_done = (tick_cnt == TW'(CHARGE_TICK - 1));

  // One bit wider than charge_bar so the add cannot wrap before saturation.
  assign charge_sum  = {1'b0, charge_bar} + STEP_W;
  assign charge_next = (charge_sum > MAX_W) ? MAX_W[PHY_WIDTH-1:0]
                                            : charge_sum[PHY_WIDTH-1:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      charge_bar     <= '0;
      jmp.jump_valid <= 1'b0;
      jmp.jump_power <= '0;
    end else begin
      case (state)
        IDLE: begin
          charge_bar     <= '0;
          jmp.jump_valid <= 1'b0;
          // Only a fresh edge starts a charge; a held button never does.
          if (press && on_ground) begin
            state      <= CHARGING;
            charge_bar <= PHY_WIDTH'(1);
            tick_cnt   <= '0;
          end
        end
        CHARGING: begin
          // Priority: abort > release > tick. A tick coinciding with the
          // release is dropped so jump_power is the pre-increment value.
          if (!on_ground) begin
            state      <= IDLE;
            charge_bar <= '0;
          end else if (rel) begin
            state          <= FIRE;
            jmp.jump_power <= charge_bar;
            jmp.jump_valid <= 1'b1;
            charge_bar     <= '0;
          end else if (tick_done) begin
            tick_cnt   <= '0;
            charge_bar <= charge_next;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        FIRE: begin
          if (jmp.jump_ready) begin
            state          <= IDLE;
            jmp.jump_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_charge_controller.sv
// tb/tb_jump_charge_controller.sv - self-checking bench for jump_charge_controller
module tb_jump_charge_controller;

  localparam int W    = 16;
  localparam int DEB  = 4;
  localparam int TICK = 3;
  localparam int MAXC = 10;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         btn_jump;
  logic         on_ground;
  logic [W-1:0] charge_bar;

  jump_charge_controller_if #(.PHY_WIDTH(W)) jif ();

  jump_charge_controller #(
    .PHY_WIDTH       (W),
    .DEBOUNCE_CYCLES (DEB),
    .CHARGE_TICK     (TICK),
    .CHARGE_STEP     (1),
    .MAX_CHARGE      (MAXC)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .btn_jump   (btn_jump),
    .on_ground  (on_ground),
    .charge_bar (charge_bar),
    .jmp        (jif.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int           hold;
    int           delay;
    bit           press_in_fire;
    logic [W-1:0] exp_power;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected live charge k cycles after the value 1 first appears.
  function automatic int ramp(input int k);
    int v;
    v = 1 + k / TICK;
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Scoreboard: every transfer (valid & ready seen before an edge) pops one entry.
  initial begin
    forever begin
      @(negedge sys_clk);
      #1;
      if (sys_rst_n && jif.jump_valid && jif.jump_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_transfer: got power %0d expected no transfer", jif.jump_power);
        end else begin
          chk("sb_jump_power", 32'(jif.jump_power), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_charge(output bit ok, input string tag);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (charge_bar == W'(1)) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_press_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic run_jump(input int hold, input int delay, input bit pif,
                          input logic [W-1:0] exp_power, input string tag);
    bit ok;
    btn_jump = 1'b1;
    wait_charge(ok, tag);
    if (!ok) begin
      btn_jump = 1'b0;
      repeat (20) @(negedge sys_clk);
      return;
    end
    for (int k = 0; k <= hold + 6; k++) begin
      if (k > 0) @(negedge sys_clk);
      chk({tag, "_ramp"}, 32'(charge_bar), 32'(ramp(k)));
      if (k == hold) begin
        jif.jump_ready = (delay == 0);
        btn_jump       = 1'b0;
        exp_q.push_back(exp_power);
      end
    end
    @(negedge sys_clk);
    chk({tag, "_valid_rise"}, 32'(jif.jump_valid), 32'd1);
    chk({tag, "_charge_cleared"}, 32'(charge_bar), 32'd0);
    for (int n = 0; n <= delay; n++) begin
      if (n > 0) @(negedge sys_clk);
      chk({tag, "_valid_held"}, 32'(jif.jump_valid), 32'd1);
      chk({tag, "_power_held"}, 32'(jif.jump_power), 32'(exp_power));
      if (n == 0 && pif) btn_jump = 1'b1;
      if (n == delay) jif.jump_ready = 1'b1;
    end
    @(negedge sys_clk);
    chk({tag, "_valid_fall"}, 32'(jif.jump_valid), 32'd0);
    chk({tag, "_charge_after"}, 32'(charge_bar), 32'd0);
    jif.jump_ready = 1'b0;
    if (pif) begin
      repeat (10) begin
        @(negedge sys_clk);
        chk({tag, "_held_no_charge"}, 32'(charge_bar), 32'd0);
      end
      btn_jump = 1'b0;
      repeat (10) begin
        @(negedge sys_clk);
        chk({tag, "_idle_charge"}, 32'(charge_bar), 32'd0);
        chk({tag, "_idle_valid"}, 32'(jif.jump_valid), 32'd0);
      end
    end else begin
      repeat (10) @(negedge sys_clk);
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{hold: 20,  delay: 0, press_in_fire: 1'b0, exp_power: 16'd9};
    vecs[1] = '{hold: 100, delay: 0, press_in_fire: 1'b0, exp_power: 16'd10};
    vecs[2] = '{hold: 0,   delay: 0, press_in_fire: 1'b0, exp_power: 16'd3};
    vecs[3] = '{hold: 3,   delay: 2, press_in_fire: 1'b0, exp_power: 16'd4};
    vecs[4] = '{hold: 5,   delay: 7, press_in_fire: 1'b1, exp_power: 16'd4};

    sys_rst_n      = 1'b0;
    btn_jump       = 1'b0;
    on_ground      = 1'b1;
    jif.jump_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset_charge", 32'(charge_bar), 32'd0);
    chk("reset_valid", 32'(jif.jump_valid), 32'd0);
    chk("reset_power", 32'(jif.jump_power), 32'd0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Bounce rejection: 2-cycle pulses never satisfy the stability count.
    for (int i = 0; i < 20; i++) begin
      btn_jump = ((i / 2) % 2 == 0);
      @(negedge sys_clk);
      chk("bounce_charge", 32'(charge_bar), 32'd0);
      chk("bounce_valid", 32'(jif.jump_valid), 32'd0);
    end
    btn_jump = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      chk("bounce_settle_charge", 32'(charge_bar), 32'd0);
    end

    for (int v = 0; v < 5; v++) begin
      run_jump(vecs[v].hold, vecs[v].delay, vecs[v].press_in_fire,
               vecs[v].exp_power, $sformatf("vec%0d", v));
    end

    // Abort by leaving the ground mid-charge, then a held button must not recharge.
    btn_jump = 1'b1;
    wait_charge(ok, "abort");
    repeat (4) @(negedge sys_clk);
    on_ground = 1'b0;
    @(negedge sys_clk);
    chk("abort_charge", 32'(charge_bar), 32'd0);
    chk("abort_valid", 32'(jif.jump_valid), 32'd0);
    repeat (4) @(negedge sys_clk);
    on_ground = 1'b1;
    repeat (10) begin
      @(negedge sys_clk);
      chk("abort_held_charge", 32'(charge_bar), 32'd0);
    end
    btn_jump = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      chk("abort_release_valid", 32'(jif.jump_valid), 32'd0);
      chk("abort_release_charge", 32'(charge_bar), 32'd0);
    end
    run_jump(0, 0, 1'b0, 16'd3, "repress");

    // Reset while a jump is pending: no transfer, outputs cleared at once.
    btn_jump = 1'b1;
    wait_charge(ok, "rstfire");
    btn_jump = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (jif.jump_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("rstfire_valid_seen", 32'(ok), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("rstfire_charge", 32'(charge_bar), 32'd0);
    chk("rstfire_valid", 32'(jif.jump_valid), 32'd0);
    chk("rstfire_power", 32'(jif.jump_power), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) begin
      @(negedge sys_clk);
      chk("post_rst_valid", 32'(jif.jump_valid), 32'd0);
      chk("post_rst_charge", 32'(charge_bar), 32'd0);
    end
    run_jump(3, 0, 1'b0, 16'd4, "post_rst");

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
